// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encodings,
// the reserved-code decode rule and the default register address width.
package hazard_stall_controller_pkg;

    localparam int ADDR_LEN_DEF = 5;

    // 2'b10 is reserved and 2'b11 is unused; neither is ever loaded.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01
    } ctrl_state_e;

    // Any encoding other than STALL is treated as RUN.
    function automatic ctrl_state_e decode_state(input logic [1:0] s);
        return (s == ST_STALL) ? ST_STALL : ST_RUN;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_load_use_detector.sv
// Combinational load-use compare between the ID operands and the load in EX.
// Register 0 never produces a hazard.
module load_use_detector
    import hazard_stall_controller_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic [ADDR_LEN-1:0] id_rs_addr,
    input  logic [ADDR_LEN-1:0] id_rt_addr,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [ADDR_LEN-1:0] ex_wb_addr,
    input  logic                ex_mem_read,
    output logic                hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs && (id_rs_addr == ex_wb_addr);
    assign rt_hit = id_use_rt && (id_rt_addr == ex_wb_addr);
    assign hazard = ex_mem_read && (ex_wb_addr != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: freeze on data-memory wait, flush on taken
// branch, multi-cycle load-use bubbles. Optional HAZARD_PERF_COUNTERS_EN adds counters.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int ADDR_LEN        = ADDR_LEN_DEF,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_LEN-1:0] id_rs_addr,
    input  logic [ADDR_LEN-1:0] id_rt_addr,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [ADDR_LEN-1:0] ex_wb_addr,
    input  logic                ex_mem_read,
    input  logic                ex_branch_taken,
    input  logic                dmem_busy,
    output logic                pc_we,
    output logic                if_id_we,
    output logic                if_id_flush,
    output logic                id_ex_we,
    output logic                id_ex_flush,
    output logic                ex_mem_we,
    output logic                mem_wb_flush,
    output logic [1:0]          ctrl_state
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    flush_count,
    output logic [CNT_W-1:0]    freeze_cycles
`endif
);

    if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 7 || CNT_W < 1) begin : g_param_err
        $error("hazard_stall_controller: LOAD_USE_STALLS must be 1..7 and CNT_W >= 1");
    end

    localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALLS - 1);

    ctrl_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    ctrl_state_e cur_st;
    logic        hazard;
    logic        bubble_ev;
    logic        branch_ev;

    load_use_detector #(
        .ADDR_LEN(ADDR_LEN)
    ) u_load_use_detector (
        .id_rs_addr (id_rs_addr),
        .id_rt_addr (id_rt_addr),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_wb_addr (ex_wb_addr),
        .ex_mem_read(ex_mem_read),
        .hazard     (hazard)
    );

    assign cur_st     = decode_state(state_q);
    assign ctrl_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b1;
        mem_wb_flush = 1'b0;
        bubble_ev    = 1'b0;
        branch_ev    = 1'b0;
        // Reset drives the outputs directly so an async assert takes effect at once.
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (dmem_busy) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            branch_ev   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = 3'd0;
        end else if (cur_st == ST_STALL || hazard) begin
            bubble_ev   = 1'b1;
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            if (cur_st == ST_STALL) begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end else if (LOAD_USE_STALLS > 1) begin
                state_d = ST_STALL;
                cnt_d   = STALL_INIT;
            end
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, flush_q, freeze_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            if (bubble_ev) stall_q  <= sat_inc(stall_q);
            if (branch_ev) flush_q  <= sat_inc(flush_q);
            if (dmem_busy) freeze_q <= sat_inc(freeze_q);
        end
    end

    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;
    assign freeze_cycles = freeze_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (1 and 3 load-use bubbles)
// driven with shared stimulus, compared against table expectations via a queue.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs_addr, id_rt_addr, ex_wb_addr;
    logic       id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken, dmem_busy;

    logic       pc_we1, if_id_we1, if_id_flush1, id_ex_we1, id_ex_flush1, ex_mem_we1, mem_wb_flush1;
    logic       pc_we3, if_id_we3, if_id_flush3, id_ex_we3, id_ex_flush3, ex_mem_we3, mem_wb_flush3;
    logic [1:0] st1, st3;
    logic [8:0] act1, act3;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [15:0] sc1, fc1, zc1, sc3, fc3, zc3;
`endif

    hazard_stall_controller #(.ADDR_LEN(5), .LOAD_USE_STALLS(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_wb_addr(ex_wb_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we1), .if_id_we(if_id_we1), .if_id_flush(if_id_flush1),
        .id_ex_we(id_ex_we1), .id_ex_flush(id_ex_flush1), .ex_mem_we(ex_mem_we1),
        .mem_wb_flush(mem_wb_flush1), .ctrl_state(st1)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .stall_cycles(sc1), .flush_count(fc1), .freeze_cycles(zc1)
`endif
    );

    hazard_stall_controller #(.ADDR_LEN(5), .LOAD_USE_STALLS(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_wb_addr(ex_wb_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we3), .if_id_we(if_id_we3), .if_id_flush(if_id_flush3),
        .id_ex_we(id_ex_we3), .id_ex_flush(id_ex_flush3), .ex_mem_we(ex_mem_we3),
        .mem_wb_flush(mem_wb_flush3), .ctrl_state(st3)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .stall_cycles(sc3), .flush_count(fc3), .freeze_cycles(zc3)
`endif
    );

    // Packed order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, state[1:0]
    assign act1 = {pc_we1, if_id_we1, if_id_flush1, id_ex_we1, id_ex_flush1, ex_mem_we1, mem_wb_flush1, st1};
    assign act3 = {pc_we3, if_id_we3, if_id_flush3, id_ex_we3, id_ex_flush3, ex_mem_we3, mem_wb_flush3, st3};

    localparam logic [8:0] NORM  = 9'b110101_0_00;
    localparam logic [8:0] LU_R  = 9'b000111_0_00;
    localparam logic [8:0] LU_S  = 9'b000111_0_01;
    localparam logic [8:0] FRZ_R = 9'b000000_1_00;
    localparam logic [8:0] FRZ_S = 9'b000000_1_01;
    localparam logic [8:0] BR_R  = 9'b111111_0_00;
    localparam logic [8:0] BR_S  = 9'b111111_0_01;
    localparam logic [8:0] RST   = 9'b001010_1_00;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, wb;
        logic       urs, urt, mr, br, busy;
        logic [8:0] e1, e3;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] e1, e3;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string n, logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                                logic [4:0] wb, logic mr, logic br, logic busy,
                                logic [8:0] e1, logic [8:0] e3);
        vec_t v;
        v.name = n; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
        v.wb = wb; v.mr = mr; v.br = br; v.busy = busy; v.e1 = e1; v.e3 = e3;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        id_rs_addr = v.rs; id_use_rs = v.urs; id_rt_addr = v.rt; id_use_rt = v.urt;
        ex_wb_addr = v.wb; ex_mem_read = v.mr; ex_branch_taken = v.br; dmem_busy = v.busy;
        e.name = v.name; e.e1 = v.e1; e.e3 = v.e3;
        sb.push_back(e);
    endtask

    task automatic cmp(input string n, input logic [8:0] a, input logic [8:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            cmp({e.name, "/lus1"}, act1, e.e1);
            cmp({e.name, "/lus3"}, act3, e.e3);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1 drive(v);
        @(negedge clk);
        check();
    endtask

    initial begin
        exp_t er;
        vec_t idle;
        idle = mk("idle", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, NORM);

        //            name          rs urs rt urt wb mr br busy  lus1   lus3
        vt.push_back(mk("normal",     5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, NORM,  NORM));
        vt.push_back(mk("lu_rs5",     5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, LU_R,  LU_R));
        vt.push_back(mk("lu_b2",      5'd5, 1, 5'd0, 0, 5'd5, 0, 0, 0, NORM,  LU_S));
        vt.push_back(mk("lu_b3",      5'd5, 1, 5'd0, 0, 5'd5, 0, 0, 0, NORM,  LU_S));
        vt.push_back(mk("lu_done",    5'd5, 1, 5'd0, 0, 5'd5, 0, 0, 0, NORM,  NORM));
        vt.push_back(mk("reg0",       5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, NORM,  NORM));
        vt.push_back(mk("rt_unused",  5'd1, 0, 5'd7, 0, 5'd7, 1, 0, 0, NORM,  NORM));
        vt.push_back(mk("rs_miss",    5'd3, 1, 5'd5, 0, 5'd5, 1, 0, 0, NORM,  NORM));
        vt.push_back(mk("lu_rt7",     5'd1, 0, 5'd7, 1, 5'd7, 1, 0, 0, LU_R,  LU_R));
        vt.push_back(mk("frz_b2",     5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, FRZ_R, FRZ_S));
        vt.push_back(mk("b2",         5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, NORM,  LU_S));
        vt.push_back(mk("frz_b3",     5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, FRZ_R, FRZ_S));
        vt.push_back(mk("b3",         5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, NORM,  LU_S));
        vt.push_back(mk("after_frz",  5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, NORM,  NORM));
        vt.push_back(mk("lu_again",   5'd9, 1, 5'd0, 0, 5'd9, 1, 0, 0, LU_R,  LU_R));
        vt.push_back(mk("br_stall",   5'd9, 1, 5'd0, 0, 5'd9, 1, 1, 0, BR_R,  BR_S));
        vt.push_back(mk("after_br",   5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, NORM,  NORM));
        vt.push_back(mk("all3",       5'd4, 1, 5'd0, 0, 5'd4, 1, 1, 1, FRZ_R, FRZ_R));
        vt.push_back(mk("br_hz",      5'd4, 1, 5'd0, 0, 5'd4, 1, 1, 0, BR_R,  BR_R));
        vt.push_back(mk("after_all",  5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, NORM,  NORM));

        rst_n = 1'b0;
        drive(idle);
        void'(sb.pop_front());
        #3;
        er.name = "reset"; er.e1 = RST; er.e3 = RST;
        sb.push_back(er);
        check();
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vt[i]) step(vt[i]);

        step(mk("pre_rst_lu", 5'd6, 1, 5'd0, 0, 5'd6, 1, 0, 0, LU_R, LU_R));
        step(mk("pre_rst_b2", 5'd6, 1, 5'd0, 0, 5'd6, 0, 0, 0, NORM, LU_S));
        #2 rst_n = 1'b0;
        #1;
        er.name = "async_rst"; er.e1 = RST; er.e3 = RST;
        sb.push_back(er);
        check();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
`ifdef HAZARD_PERF_COUNTERS_EN
        cmp("cnt_clear1", {sc1[2:0], fc1[2:0], zc1[2:0]}, 9'd0);
        cmp("cnt_clear3", {sc3[2:0], fc3[2:0], zc3[2:0]}, 9'd0);
`endif
        step(mk("post_rst", 5'd6, 1, 5'd0, 0, 5'd6, 0, 0, 0, NORM, NORM));

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage hardware-scheduled MIPS pipeline. It sits beside the forwarding unit.
- Detects load-use hazards that forwarding cannot cover, branch-taken flushes and data-memory wait.
- Drives per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Multi-cycle load-use stalls are sequenced by an internal FSM and counter.

Parameters:
- ADDR_LEN, 5, register address width.
- LOAD_USE_STALLS, 1, bubble cycles per load-use hazard; legal range 1..7.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- id_rs_addr  input  ADDR_LEN  rs of the instruction in ID.
- id_rt_addr  input  ADDR_LEN  rt of the instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- ex_wb_addr  input  ADDR_LEN  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  branch/jump in EX resolved taken.
- dmem_busy  input  1  data memory not ready this cycle.
- pc_we  output  1  PC load enable.
- if_id_we  output  1  IF/ID register enable.
- if_id_flush  output  1  IF/ID clear to NOP.
- id_ex_we  output  1  ID/EX register enable.
- id_ex_flush  output  1  ID/EX clear to bubble.
- ex_mem_we  output  1  EX/MEM register enable.
- mem_wb_flush  output  1  MEM/WB clear to bubble.
- ctrl_state  output  2  current FSM state encoding.

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous and active-low.
- While rst_n=0:
  - state=RUN, cnt=0.
  - pc_we, if_id_we, id_ex_we and ex_mem_we are 0.
  - if_id_flush, id_ex_flush and mem_wb_flush are 1.
  - The first cycle after release is normal RUN.
- Reset asserted mid-stall or mid-freeze aborts immediately, with no pending state retained.
- States:
  - RUN=2'b00.
  - STALL=2'b01.
  - ctrl_state=2'b10 is reserved (FREEZE is not a separate state; see below). Encoding 2'b11 is unused and decodes to RUN.
- Outputs are combinational from state and inputs; the state and counter are registered.
- hazard = ex_mem_read && ex_wb_addr!=0 && ((id_use_rs && id_rs_addr==ex_wb_addr) || (id_use_rt && id_rt_addr==ex_wb_addr)). Register 0 never hazards.
- Priority each cycle: dmem_busy > ex_branch_taken > hazard / STALL.
- Freeze (dmem_busy=1, any state):
  - pc_we=0, if_id_we=0, id_ex_we=0, ex_mem_we=0, mem_wb_flush=1; other flushes 0.
  - State and cnt hold.
- Branch (not busy, ex_branch_taken=1):
  - pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=1, ex_mem_we=1.
  - hazard is ignored.
  - From STALL the stall aborts: next state RUN, cnt=0.
- Load-use (RUN, not busy, no branch, hazard=1):
  - pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1.
  - If LOAD_USE_STALLS>1: next state STALL, cnt=LOAD_USE_STALLS-1. Otherwise remain in RUN.
- STALL (not busy, no branch):
  - Same outputs as load-use.
  - cnt decrements; when cnt==1 the next state is RUN.
  - The total bubble count is exactly LOAD_USE_STALLS.
- Normal (RUN, no event): all enables 1, all flushes 0.
- Flush signals take precedence over the matching write enable within the pipeline registers. When a flush is asserted the controller still drives the enable to 1, except in freeze.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- When defined, adds these output ports, each CNT_W wide:
  - stall_cycles: cycles with id_ex_flush due to load-use/STALL.
  - flush_count: branch flush events.
  - freeze_cycles: cycles with dmem_busy.
- The counters saturate at all-ones and are cleared by rst_n.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds the state encodings (RUN, STALL), the 2'b11-decodes-to-RUN rule, and the ADDR_LEN default.
- One natural sub-module, load_use_detector: the purely combinational hazard compare, reusable by the decode stage. The FSM, counter and output decode stay in the top module.

Test Plan:
- Load-use, LOAD_USE_STALLS=1: ex_mem_read=1, ex_wb_addr=5, id_rs_addr=5, id_use_rs=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; then normal, ctrl_state=00 throughout.
- Register 0 and unused operand: ex_wb_addr=0 with matching rs, or id_use_rt=0 with rt match -> no stall.
- LOAD_USE_STALLS=3 with hazard -> exactly 3 bubble cycles, ctrl_state=01 for cycles 2–3, then RUN. Assert dmem_busy during cycle 2 -> all enables 0, mem_wb_flush=1, cnt held, 3 bubbles total still.
- Branch during STALL -> if_id_flush=1, id_ex_flush=1, pc_we=1 that cycle; next cycle RUN with all enables 1.
- Simultaneous dmem_busy=1, ex_branch_taken=1, hazard=1 -> freeze outputs only. Drop busy next cycle -> branch flush outputs.
- Assert rst_n=0 asynchronously mid-STALL -> outputs take reset values immediately. After release, RUN; with HAZARD_PERF_COUNTERS_EN, all counters read 0.
